seg7_scan_capture: RTL and testbench

//  Receive side of the multiplexed 6-digit 7-segment display bus (active-low digit selects + 8-bit segment word).

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/seg7_pattern_decode.sv | 35 +++
 rtl/seg7_scan_capture.sv | 208 ++++++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan capture block.
package seg7_pkg;

  // Segment patterns (gfedcba, active-high) for the digits the display can show
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  // First select of a frame (slot 0 active) and the BCD code stored for a dash
  localparam logic [5:0] DIG_FIRST = 6'b111110;
  localparam logic [3:0] BCD_DASH  = 4'hF;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_SETTLE,
    ST_CAPTURE,
    ST_HOLD
  } state_t;

  // Two BCD digits to binary: tens*8 + tens*2 + units, at most 99
  function automatic logic [6:0] pair_value(input logic [3:0] tens, input logic [3:0] units);
    return {tens, 3'b000} + 7'({tens, 1'b0}) + 7'(units);
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of a 7-segment pattern back to BCD, flagging dash and illegal patterns.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] bcd,
  output logic       is_dash,
  output logic       illegal
);

  // Table lookup; anything not in the digit set (including all-off) is illegal
  always_comb begin
    bcd     = 4'd0;
    is_dash = 1'b0;
    illegal = 1'b0;
    case (pattern)
      SEG_0:    bcd = 4'd0;
      SEG_1:    bcd = 4'd1;
      SEG_2:    bcd = 4'd2;
      SEG_3:    bcd = 4'd3;
      SEG_4:    bcd = 4'd4;
      SEG_5:    bcd = 4'd5;
      SEG_6:    bcd = 4'd6;
      SEG_7:    bcd = 4'd7;
      SEG_8:    bcd = 4'd8;
      SEG_9:    bcd = 4'd9;
      SEG_DASH: begin
        bcd     = BCD_DASH;
        is_dash = 1'b1;
      end
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Follows a multiplexed 6-digit 7-segment scan, decodes each digit after it settles,
// and publishes whole frames as BCD plus binary L/M/B pair values.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  dig_n,
  input  logic [7:0]  seg,
  output logic        frame_valid,
  output logic [23:0] bcd,
  output logic [5:0]  dp_mask,
  output logic [5:0]  dash_mask,
  output logic [6:0]  l_val,
  output logic [6:0]  m_val,
  output logic [6:0]  b_val,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  state_t          state_reg, state_next;
  logic [5:0]      exp_reg, exp_next;
  logic [2:0]      cnt_reg, cnt_next;
  logic [SW-1:0]   settle_reg, settle_next;
  logic [TW-1:0]   tmo_reg;
  logic [5:0]      dig_prev_reg;

  logic            frame_valid_reg, err_reg;
  logic [23:0]     bcd_reg;
  logic [5:0]      dp_mask_reg, dash_mask_reg;
  logic [6:0]      l_val_reg, m_val_reg, b_val_reg;

  logic [3:0]      dec_bcd;
  logic            dec_dash, dec_illegal;
  logic            capture_en, publish, err_evt, tmo_hit;

  // Partial-frame shadow, one slot per generate instance
  logic [23:0]     bcd_sh;
  logic [5:0]      dp_sh, dash_sh;

  seg7_pattern_decode u_decode (
    .pattern (seg[6:0]),
    .bcd     (dec_bcd),
    .is_dash (dec_dash),
    .illegal (dec_illegal)
  );

  assign tmo_hit = (state_reg != ST_SYNC) && (tmo_reg == TW'(TIMEOUT_CYCLES));

  // Next-state logic: scan tracking, capture strobe, publish and error events
  always_comb begin
    state_next  = state_reg;
    exp_next    = exp_reg;
    cnt_next    = cnt_reg;
    settle_next = settle_reg;
    capture_en  = 1'b0;
    publish     = 1'b0;
    err_evt     = 1'b0;
    if (tmo_hit) begin
      err_evt    = 1'b1;
      state_next = ST_SYNC;
    end else begin
      case (state_reg)
        ST_SYNC: begin
          if (dig_n == DIG_FIRST) begin
            exp_next    = DIG_FIRST;
            cnt_next    = 3'd0;
            settle_next = '0;
            state_next  = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (dig_n != exp_reg) begin
            err_evt    = 1'b1;
            state_next = ST_SYNC;
          end else if (settle_reg == SW'(SETTLE_CYCLES - 1)) begin
            state_next = ST_CAPTURE;
          end else begin
            settle_next = settle_reg + 1'b1;
          end
        end
        ST_CAPTURE: begin
          // A select change here is a glitch; an undecodable pattern discards the frame
          if ((dig_n != exp_reg) || dec_illegal) begin
            err_evt    = 1'b1;
            state_next = ST_SYNC;
          end else begin
            capture_en = 1'b1;
            cnt_next   = cnt_reg + 1'b1;
            state_next = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (dig_n != exp_reg) begin
            if (dig_n == {exp_reg[0], exp_reg[5:1]}) begin
              if (cnt_reg == 3'd6) begin
                publish  = 1'b1;
                cnt_next = 3'd0;
              end
              exp_next    = dig_n;
              settle_next = '0;
              state_next  = ST_SETTLE;
            end else begin
              err_evt    = 1'b1;
              state_next = ST_SYNC;
            end
          end
        end
        default: state_next = ST_SYNC;
      endcase
    end
  end

  // FSM and scan-tracking registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_SYNC;
      exp_reg    <= DIG_FIRST;
      cnt_reg    <= 3'd0;
      settle_reg <= '0;
    end else begin
      state_reg  <= state_next;
      exp_reg    <= exp_next;
      cnt_reg    <= cnt_next;
      settle_reg <= settle_next;
    end
  end

  // Stall timer: restarts on every select change, idle in SYNC, saturates at the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_reg      <= '0;
      dig_prev_reg <= '1;
    end else begin
      dig_prev_reg <= dig_n;
      if ((state_reg == ST_SYNC) || (dig_n != dig_prev_reg)) begin
        tmo_reg <= '0;
      end else if (tmo_reg != TW'(TIMEOUT_CYCLES)) begin
        tmo_reg <= tmo_reg + 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_slot
      logic [3:0] bcd_slot_reg;
      logic       dp_slot_reg;
      logic       dash_slot_reg;

      // Store the decoded digit when this slot's select is the one being captured
      always_ff @(posedge clk) begin
        if (rst) begin
          bcd_slot_reg  <= 4'd0;
          dp_slot_reg   <= 1'b0;
          dash_slot_reg <= 1'b0;
        end else if (capture_en && !exp_reg[gi]) begin
          bcd_slot_reg  <= dec_bcd;
          dp_slot_reg   <= seg[7];
          dash_slot_reg <= dec_dash;
        end
      end

      assign bcd_sh[gi*4 +: 4] = bcd_slot_reg;
      assign dp_sh[gi]         = dp_slot_reg;
      assign dash_sh[gi]       = dash_slot_reg;
    end
  endgenerate

  // Published outputs: loaded only on a completed frame; err and publish never coincide
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_valid_reg <= 1'b0;
      err_reg         <= 1'b0;
      bcd_reg         <= '0;
      dp_mask_reg     <= '0;
      dash_mask_reg   <= '0;
      l_val_reg       <= '0;
      m_val_reg       <= '0;
      b_val_reg       <= '0;
    end else begin
      frame_valid_reg <= publish;
      err_reg         <= err_evt;
      if (publish) begin
        bcd_reg       <= bcd_sh;
        dp_mask_reg   <= dp_sh;
        dash_mask_reg <= dash_sh;
        l_val_reg     <= (dash_sh[0] | dash_sh[1]) ? 7'd127 : pair_value(bcd_sh[7:4],   bcd_sh[3:0]);
        m_val_reg     <= (dash_sh[2] | dash_sh[3]) ? 7'd127 : pair_value(bcd_sh[15:12], bcd_sh[11:8]);
        b_val_reg     <= (dash_sh[4] | dash_sh[5]) ? 7'd127 : pair_value(bcd_sh[23:20], bcd_sh[19:16]);
      end
    end
  end

  assign frame_valid = frame_valid_reg;
  assign err         = err_reg;
  assign bcd         = bcd_reg;
  assign dp_mask     = dp_mask_reg;
  assign dash_mask   = dash_mask_reg;
  assign l_val       = l_val_reg;
  assign m_val       = m_val_reg;
  assign b_val       = b_val_reg;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Self-checking bench: a 50-cycle-step display model drives the scan, a frame-level
// reference model predicts each published frame.
module tb_seg7_scan_capture;

  localparam int STEP = 50;
  localparam int TMO  = 500;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  dig_n;
  logic [7:0]  seg;
  logic        frame_valid;
  logic [23:0] bcd;
  logic [5:0]  dp_mask, dash_mask;
  logic [6:0]  l_val, m_val, b_val;
  logic        err;

  always #5 clk = ~clk;

  seg7_scan_capture #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .dig_n(dig_n), .seg(seg),
    .frame_valid(frame_valid), .bcd(bcd), .dp_mask(dp_mask), .dash_mask(dash_mask),
    .l_val(l_val), .m_val(m_val), .b_val(b_val), .err(err)
  );

  typedef struct packed {
    logic [23:0] bcd;
    logic [5:0]  dp;
    logic [5:0]  dash;
    logic [6:0]  l;
    logic [6:0]  m;
    logic [6:0]  b;
  } rec_t;

  rec_t pub_arr [64];
  int   pub_total = 0;
  int   err_total = 0;
  int   checks    = 0;
  int   failures  = 0;

  // Monitor: record every published frame and count error pulses
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      if (pub_total < 64) pub_arr[pub_total] = '{bcd, dp_mask, dash_mask, l_val, m_val, b_val};
      pub_total++;
    end
    if (err === 1'b1) err_total++;
  end

  // Digit code 0..9, 10 = dash
  function automatic logic [7:0] seg_of(input logic [3:0] d, input logic dp);
    logic [6:0] p;
    case (d)
      4'd0: p = 7'h3F;  4'd1: p = 7'h06;  4'd2: p = 7'h5B;  4'd3: p = 7'h4F;
      4'd4: p = 7'h66;  4'd5: p = 7'h6D;  4'd6: p = 7'h7D;  4'd7: p = 7'h07;
      4'd8: p = 7'h7F;  4'd9: p = 7'h6F;  4'd10: p = 7'h40;
      default: p = 7'h00;
    endcase
    return {dp, p};
  endfunction

  function automatic bit is_legal(input logic [6:0] p);
    logic [7:0] s;
    for (int v = 0; v <= 10; v++) begin
      s = seg_of(4'(v), 1'b0);
      if (s[6:0] == p) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [6:0] pair_ref(input logic [3:0] tens, input logic [3:0] units);
    if (tens == 4'd10 || units == 4'd10) return 7'd127;
    return 7'(10 * int'(tens) + int'(units));
  endfunction

  // Reference model: what a complete frame of digits should publish
  function automatic rec_t model(input logic [5:0][3:0] d, input logic [5:0] dp);
    rec_t r;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r.bcd[i*4 +: 4] = (d[i] == 4'd10) ? 4'hF : d[i];
      r.dash[i]       = (d[i] == 4'd10);
    end
    r.dp = dp;
    r.l  = pair_ref(d[1], d[0]);
    r.m  = pair_ref(d[3], d[2]);
    r.b  = pair_ref(d[5], d[4]);
    return r;
  endfunction

  function automatic logic [5:0][3:0] rand_digits(input bit allow_dash);
    logic [5:0][3:0] d;
    for (int i = 0; i < 6; i++) begin
      if (allow_dash && $urandom_range(0, 7) == 0) d[i] = 4'd10;
      else d[i] = 4'($urandom_range(0, 9));
    end
    return d;
  endfunction

  task automatic show_slot(input int slot, input logic [7:0] pat);
    @(negedge clk);
    dig_n = ~(6'b000001 << slot);
    seg   = pat;
    repeat (STEP - 1) @(negedge clk);
  endtask

  // One frame in scan order 0,5,4,3,2,1; bad_slot (if >= 0) shows bad_pat instead
  task automatic drive_frame(input logic [5:0][3:0] d, input logic [5:0] dp,
                             input int bad_slot, input logic [7:0] bad_pat);
    int order [6] = '{0, 5, 4, 3, 2, 1};
    for (int k = 0; k < 6; k++) begin
      if (order[k] == bad_slot) show_slot(order[k], bad_pat);
      else show_slot(order[k], seg_of(d[order[k]], dp[order[k]]));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    dig_n = 6'b111111;
    seg   = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    dig_n = 6'b111111;
    seg   = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_frame_valid got=%b exp=0", frame_valid); end
    checks++; if (err !== 1'b0)         begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (bcd !== 24'h0)        begin failures++; $display("FAIL reset_bcd got=%h exp=0", bcd); end
    checks++; if (dp_mask !== 6'h0)     begin failures++; $display("FAIL reset_dp got=%b exp=0", dp_mask); end
    checks++; if (dash_mask !== 6'h0)   begin failures++; $display("FAIL reset_dash got=%b exp=0", dash_mask); end
    checks++; if (l_val !== 7'd0)       begin failures++; $display("FAIL reset_l got=%0d exp=0", l_val); end
    checks++; if (m_val !== 7'd0)       begin failures++; $display("FAIL reset_m got=%0d exp=0", m_val); end
    checks++; if (b_val !== 7'd0)       begin failures++; $display("FAIL reset_b got=%0d exp=0", b_val); end
    rst = 1'b0;
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_frames();
    logic [5:0][3:0] d;
    logic [5:0]      dp;
    rec_t            exp_r [6];
    rec_t            got;
    int              base, ebase;
    do_reset();
    base  = pub_total;
    ebase = err_total;
    d  = {4'd0, 4'd5, 4'd1, 4'd2, 4'd3, 4'd7};
    dp = 6'b010100;
    exp_r[0] = model(d, dp);
    drive_frame(d, dp, -1, 8'h00);
    for (int k = 1; k < 6; k++) begin
      d  = rand_digits(1'b1);
      dp = 6'($urandom);
      exp_r[k] = model(d, dp);
      drive_frame(d, dp, -1, 8'h00);
    end
    checks++; if (pub_total - base != 5) begin failures++; $display("FAIL frames_before_last_step got=%0d exp=5", pub_total - base); end
    show_slot(0, seg_of(4'd0, 1'b0));
    checks++; if (pub_total - base != 6) begin failures++; $display("FAIL frames_count got=%0d exp=6", pub_total - base); end
    for (int k = 0; k < 6; k++) begin
      got = pub_arr[base + k];
      checks++;
      if (got !== exp_r[k]) begin
        failures++;
        $display("FAIL frame_%0d got=%h exp=%h", k, got, exp_r[k]);
      end
      $display("frame %0d bcd=%h dp=%b dash=%b l=%0d m=%0d b=%0d", k, got.bcd, got.dp, got.dash, got.l, got.m, got.b);
    end
    got = pub_arr[base];
    checks++; if (got.l !== 7'd37)        begin failures++; $display("FAIL frame1_l got=%0d exp=37", got.l); end
    checks++; if (got.m !== 7'd12)        begin failures++; $display("FAIL frame1_m got=%0d exp=12", got.m); end
    checks++; if (got.b !== 7'd5)         begin failures++; $display("FAIL frame1_b got=%0d exp=5", got.b); end
    checks++; if (got.bcd !== 24'h051237) begin failures++; $display("FAIL frame1_bcd got=%h exp=051237", got.bcd); end
    checks++; if (got.dp !== 6'b010100)   begin failures++; $display("FAIL frame1_dp got=%b exp=010100", got.dp); end
    checks++; if (err_total != ebase)     begin failures++; $display("FAIL frames_err got=%0d exp=0", err_total - ebase); end
  endtask

  task automatic test_dash();
    logic [5:0][3:0] d;
    rec_t            got;
    int              base, ebase;
    do_reset();
    base  = pub_total;
    ebase = err_total;
    d = {6{4'd10}};
    for (int k = 0; k < 3; k++) drive_frame(d, 6'($urandom), -1, 8'h00);
    show_slot(0, seg_of(4'd10, 1'b0));
    checks++; if (pub_total - base != 3) begin failures++; $display("FAIL dash_count got=%0d exp=3", pub_total - base); end
    for (int k = 0; k < 3; k++) begin
      got = pub_arr[base + k];
      $display("dash frame %0d bcd=%h dash=%b l=%0d m=%0d b=%0d", k, got.bcd, got.dash, got.l, got.m, got.b);
      checks++;
      if (got.dash !== 6'b111111 || got.bcd !== 24'hFFFFFF || got.l !== 7'd127 ||
          got.m !== 7'd127 || got.b !== 7'd127) begin
        failures++;
        $display("FAIL dash_frame_%0d got dash=%b bcd=%h l=%0d m=%0d b=%0d exp 111111/FFFFFF/127", k,
                 got.dash, got.bcd, got.l, got.m, got.b);
      end
    end
    checks++; if (err_total != ebase) begin failures++; $display("FAIL dash_err got=%0d exp=0", err_total - ebase); end
  endtask

  task automatic test_illegal();
    logic [5:0][3:0] d;
    logic [5:0]      dp;
    logic [7:0]      bad;
    rec_t            exp_r;
    int              base, ebase, slot;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      base  = pub_total;
      ebase = err_total;
      if (it == 0) begin
        slot = 3;
        bad  = 8'h00;
      end else begin
        slot = $urandom_range(0, 5);
        do bad = 8'($urandom); while (is_legal(bad[6:0]));
      end
      drive_frame(rand_digits(1'b0), 6'($urandom), slot, bad);
      d  = rand_digits(1'b1);
      dp = 6'($urandom);
      exp_r = model(d, dp);
      drive_frame(d, dp, -1, 8'h00);
      show_slot(0, seg_of(4'd0, 1'b0));
      $display("illegal it=%0d slot=%0d pat=%h errs=%0d frames=%0d", it, slot, bad, err_total - ebase, pub_total - base);
      checks++; if (err_total - ebase != 1) begin failures++; $display("FAIL illegal_err it=%0d got=%0d exp=1", it, err_total - ebase); end
      checks++; if (pub_total - base != 1)  begin failures++; $display("FAIL illegal_frames it=%0d got=%0d exp=1", it, pub_total - base); end
      checks++; if (pub_arr[base] !== exp_r) begin failures++; $display("FAIL illegal_next_frame it=%0d got=%h exp=%h", it, pub_arr[base], exp_r); end
    end
  endtask

  task automatic test_scan_error();
    logic [5:0][3:0] d;
    logic [5:0]      dp;
    rec_t            exp_r;
    int              base, ebase;
    for (int it = 0; it < 2; it++) begin
      do_reset();
      base  = pub_total;
      ebase = err_total;
      show_slot(0, seg_of(4'd1, 1'b0));
      if (it == 0) show_slot(4, seg_of(4'd2, 1'b0));   // skipped slot 5
      else         show_slot(1, seg_of(4'd2, 1'b0));   // reversed direction
      show_slot(3, seg_of(4'd3, 1'b0));
      show_slot(2, seg_of(4'd4, 1'b0));
      show_slot(1, seg_of(4'd5, 1'b0));
      d  = rand_digits(1'b0);
      dp = 6'($urandom);
      exp_r = model(d, dp);
      drive_frame(d, dp, -1, 8'h00);
      show_slot(0, seg_of(4'd0, 1'b0));
      $display("scan_error it=%0d errs=%0d frames=%0d", it, err_total - ebase, pub_total - base);
      checks++; if (err_total - ebase != 1) begin failures++; $display("FAIL scan_err it=%0d got=%0d exp=1", it, err_total - ebase); end
      checks++; if (pub_total - base != 1)  begin failures++; $display("FAIL scan_frames it=%0d got=%0d exp=1", it, pub_total - base); end
      checks++; if (pub_arr[base] !== exp_r) begin failures++; $display("FAIL scan_resync_frame it=%0d got=%h exp=%h", it, pub_arr[base], exp_r); end
    end
  endtask

  task automatic test_timeout();
    int base, ebase;
    do_reset();
    base  = pub_total;
    ebase = err_total;
    show_slot(0, seg_of(4'd1, 1'b0));
    show_slot(5, seg_of(4'd2, 1'b0));
    show_slot(4, seg_of(4'd3, 1'b0));
    @(negedge clk);
    dig_n = 6'b110111;
    seg   = seg_of(4'd4, 1'b0);
    repeat (TMO - 50) @(negedge clk);
    checks++; if (err_total != ebase) begin failures++; $display("FAIL timeout_early got=%0d exp=0", err_total - ebase); end
    repeat (3 * TMO) @(negedge clk);
    $display("timeout errs=%0d frames=%0d", err_total - ebase, pub_total - base);
    checks++; if (err_total - ebase != 1) begin failures++; $display("FAIL timeout_err got=%0d exp=1", err_total - ebase); end
    checks++; if (pub_total != base)      begin failures++; $display("FAIL timeout_frames got=%0d exp=0", pub_total - base); end
  endtask

  task automatic test_rst_mid();
    logic [5:0][3:0] d;
    logic [5:0]      dp;
    rec_t            exp_r;
    int              base, ebase;
    do_reset();
    d  = {4'd2, 4'd3, 4'd4, 4'd8, 4'd5, 4'd9};
    dp = 6'b100001;
    drive_frame(d, dp, -1, 8'h00);
    show_slot(0, seg_of(4'd1, 1'b0));
    show_slot(5, seg_of(4'd2, 1'b0));
    show_slot(4, seg_of(4'd3, 1'b0));
    checks++; if (l_val !== 7'd59) begin failures++; $display("FAIL rst_pre_l got=%0d exp=59", l_val); end
    @(negedge clk);
    dig_n = 6'b110111;
    seg   = seg_of(4'd4, 1'b0);
    rst   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (frame_valid !== 1'b0 || err !== 1'b0 || bcd !== 24'h0 || dp_mask !== 6'h0 ||
        dash_mask !== 6'h0 || l_val !== 7'd0 || m_val !== 7'd0 || b_val !== 7'd0) begin
      failures++;
      $display("FAIL rst_mid_outputs got bcd=%h dp=%b dash=%b l=%0d m=%0d b=%0d exp all 0",
               bcd, dp_mask, dash_mask, l_val, m_val, b_val);
    end
    base  = pub_total;
    ebase = err_total;
    repeat (STEP) @(negedge clk);
    show_slot(2, seg_of(4'd5, 1'b0));
    show_slot(1, seg_of(4'd6, 1'b0));
    d  = rand_digits(1'b1);
    dp = 6'($urandom);
    exp_r = model(d, dp);
    drive_frame(d, dp, -1, 8'h00);
    checks++; if (pub_total != base) begin failures++; $display("FAIL rst_early_frame got=%0d exp=0", pub_total - base); end
    show_slot(0, seg_of(4'd0, 1'b0));
    $display("rst_mid frames=%0d errs=%0d", pub_total - base, err_total - ebase);
    checks++; if (pub_total - base != 1)   begin failures++; $display("FAIL rst_frames got=%0d exp=1", pub_total - base); end
    checks++; if (pub_arr[base] !== exp_r) begin failures++; $display("FAIL rst_frame got=%h exp=%h", pub_arr[base], exp_r); end
    checks++; if (err_total != ebase)      begin failures++; $display("FAIL rst_err got=%0d exp=0", err_total - ebase); end
  endtask

  initial begin
    rst   = 1'b1;
    dig_n = 6'b111111;
    seg   = 8'h00;
    test_reset();
    test_frames();
    test_dash();
    test_illegal();
    test_scan_error();
    test_timeout();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
